// File: rtl/riscv32ima_pkg.sv
// rtl/riscv32ima_pkg.sv - shared widths, reset PC and state types for the instruction memory
package riscv32ima_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h1000_0000;

    typedef enum logic [1:0] {IDLE, WAIT, PF} imem_state_t;

    // Selects what drives i_rdata between responses.
    typedef enum logic [1:0] {SRC_ZERO, SRC_ARRAY, SRC_HOLD} rdata_src_t;
endpackage

// File: rtl/riscv32ima_imem_if.sv
// rtl/riscv32ima_imem_if.sv - i_* instruction fetch bus between fetch unit and instruction memory
interface riscv32ima_imem_if;
    import riscv32ima_pkg::*;

    logic                  i_ncs;
    logic                  i_nwe;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [DATA_WIDTH-1:0] i_wmask;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_stall;
    logic                  i_err;

    modport master (
        output i_ncs, i_nwe, i_addr, i_wdata, i_wmask,
        input  i_rdata, i_stall, i_err
    );

    modport slave (
        input  i_ncs, i_nwe, i_addr, i_wdata, i_wmask,
        output i_rdata, i_stall, i_err
    );
endinterface

// File: rtl/riscv32ima_imem_array.sv
// rtl/riscv32ima_imem_array.sv - single-port line RAM, bit-masked write, registered read
module riscv32ima_imem_array
    import riscv32ima_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] wmask_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read register only moves on a read, so it holds across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= (mem_q[idx_i] & ~wmask_i) | (wdata_i & wmask_i);
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/riscv32ima_imem.sv
// rtl/riscv32ima_imem.sv - wait-state instruction memory responder on the i_* bus
// Optional next-line prefetch buffer: RISCV32IMA_IMEM_PREFETCH_EN
module riscv32ima_imem
    import riscv32ima_pkg::*;
#(
    parameter int                    DEPTH       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = RESET_PC,
    parameter int                    WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    riscv32ima_imem_if.slave bus
);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    imem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    rdata_src_t            src_q, src_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q, wmask_q;

    logic                  accept, complete;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_off;
    logic                  cur_we, cur_oor;
    logic [IDX_W-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0] cur_wdata, cur_wmask;
    logic                  arr_en, arr_we;
    logic [IDX_W-1:0]      arr_idx;
    logic [DATA_WIDTH-1:0] arr_rdata, rdata_mux;

`ifdef RISCV32IMA_IMEM_PREFETCH_EN
    logic                  pend_q, pend_d;
    logic [IDX_W-1:0]      pf_line_q, pf_line_d;
    logic                  pf_valid_q, pf_valid_d;
    logic [IDX_W-1:0]      pf_tag_q, pf_tag_d;
    logic                  pf_fill_q, pf_fill_d;
    logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d, pf_data_w;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    // The fill lands in the array read register one cycle after the PF read.
    assign pf_data_w = pf_fill_q ? arr_rdata : pf_data_q;
`endif

    assign accept = (state_q == IDLE) && !bus.i_ncs;

    always_comb begin
        if (state_q == IDLE) begin
            cur_addr  = bus.i_addr;
            cur_we    = !bus.i_nwe;
            cur_wdata = bus.i_wdata;
            cur_wmask = bus.i_wmask;
        end else begin
            cur_addr  = addr_q;
            cur_we    = we_q;
            cur_wdata = wdata_q;
            cur_wmask = wmask_q;
        end
    end

    assign cur_off = cur_addr - BASE_ADDR;
    assign cur_oor = (cur_addr < BASE_ADDR) || ((cur_off >> 3) >= ADDR_WIDTH'(DEPTH));
    assign cur_idx = cur_off[3 +: IDX_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        err_d    = 1'b0;
        complete = 1'b0;
        arr_en   = 1'b0;
        arr_we   = cur_we;
        arr_idx  = cur_idx;
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
        pend_d     = 1'b0;
        pf_line_d  = pf_line_q;
        pf_valid_d = pf_valid_q;
        pf_tag_d   = pf_tag_q;
        pf_fill_d  = 1'b0;
        pf_data_d  = pf_data_w;
        hold_d     = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
                    if (!cur_we && !cur_oor && pf_valid_q && (pf_tag_q == cur_idx)) begin
                        hold_d    = pf_data_w;
                        src_d     = SRC_HOLD;
                        pend_d    = (cur_idx != IDX_W'(DEPTH - 1));
                        pf_line_d = cur_idx + IDX_W'(1);
                    end else
`endif
                    if (WAIT_STATES == 0) begin
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS;
                    end
                end
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
                else if (pend_q) begin
                    state_d = PF;
                    cnt_d   = WS;
                end
`endif
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
            PF: begin
                if (cnt_q == 4'd0) begin
                    arr_en     = 1'b1;
                    arr_we     = 1'b0;
                    arr_idx    = pf_line_q;
                    pf_fill_d  = 1'b1;
                    pf_valid_d = 1'b1;
                    pf_tag_d   = pf_line_q;
                    // Freeze the visible read data while the array register is reused.
                    hold_d     = rdata_mux;
                    src_d      = SRC_HOLD;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (cur_oor) begin
                err_d = 1'b1;
                if (!cur_we) begin
                    src_d = SRC_ZERO;
                end
            end else begin
                arr_en = 1'b1;
                if (!cur_we) begin
                    src_d = SRC_ARRAY;
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
                    pend_d    = (cur_idx != IDX_W'(DEPTH - 1));
                    pf_line_d = cur_idx + IDX_W'(1);
`endif
                end
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
                if (cur_we && (pf_tag_q == cur_idx)) begin
                    pf_valid_d = 1'b0;
                end
`endif
            end
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (src_q)
            SRC_ARRAY: rdata_mux = arr_rdata;
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
            SRC_HOLD:  rdata_mux = hold_q;
`endif
            default:   rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.i_addr;
            we_q    <= !bus.i_nwe;
            wdata_q <= bus.i_wdata;
            wmask_q <= bus.i_wmask;
        end
    end

`ifdef RISCV32IMA_IMEM_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_fill_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pf_valid_q <= pf_valid_d;
            pf_fill_q  <= pf_fill_d;
        end
        pf_line_q <= pf_line_d;
        pf_tag_q  <= pf_tag_d;
        pf_data_q <= pf_data_d;
        hold_q    <= hold_d;
    end
`endif

    // Gating with rst drops an access that would otherwise complete in the reset cycle.
    riscv32ima_imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (arr_en && !rst),
        .we_i    (arr_we),
        .idx_i   (arr_idx),
        .wdata_i (cur_wdata),
        .wmask_i (cur_wmask),
        .rdata_o (arr_rdata)
    );

    assign bus.i_rdata = rdata_mux;
    assign bus.i_stall = (state_q != IDLE);
    assign bus.i_err   = err_q;
endmodule

// File: tb/tb_riscv32ima_imem.sv
// tb/tb_riscv32ima_imem.sv - directed self-checking bench for riscv32ima_imem
module tb_riscv32ima_imem;
    import riscv32ima_pkg::*;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [63:0] V0    = 64'h0000_0013_0000_0093;
    localparam logic [63:0] VL    = 64'hA5A5_0000_5A5A_FFFF;
    localparam logic [63:0] V5    = 64'h1234_5678_9ABC_DEF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ncs = 3'b111;
    logic        nwe = 1'b1;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] wmask = '0;
    int          sel = 0;
    logic        stall_s, err_s;
    logic [63:0] rdata_s;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    riscv32ima_imem_if bus0 ();
    riscv32ima_imem_if bus1 ();
    riscv32ima_imem_if bus2 ();

    assign bus0.i_ncs = ncs[0];
    assign bus0.i_nwe = nwe;
    assign bus0.i_addr = addr;
    assign bus0.i_wdata = wdata;
    assign bus0.i_wmask = wmask;
    assign bus1.i_ncs = ncs[1];
    assign bus1.i_nwe = nwe;
    assign bus1.i_addr = addr;
    assign bus1.i_wdata = wdata;
    assign bus1.i_wmask = wmask;
    assign bus2.i_ncs = ncs[2];
    assign bus2.i_nwe = nwe;
    assign bus2.i_addr = addr;
    assign bus2.i_wdata = wdata;
    assign bus2.i_wmask = wmask;

    riscv32ima_imem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) u_ws2 (
        .clk (clk), .rst (rst), .bus (bus0.slave));
    riscv32ima_imem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
        .clk (clk), .rst (rst), .bus (bus1.slave));
    riscv32ima_imem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
        .clk (clk), .rst (rst), .bus (bus2.slave));

    always_comb begin
        stall_s = bus0.i_stall;
        err_s   = bus0.i_err;
        rdata_s = bus0.i_rdata;
        case (sel)
            1: begin stall_s = bus1.i_stall; err_s = bus1.i_err; rdata_s = bus1.i_rdata; end
            2: begin stall_s = bus2.i_stall; err_s = bus2.i_err; rdata_s = bus2.i_rdata; end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for acceptance, returns at the response cycle.
    task automatic req(input logic we, input logic [31:0] a, input logic [63:0] wd,
                       input logic [63:0] wm, output int stalls);
        int n;
        n = 0;
        ncs[sel] = 1'b0;
        nwe = ~we;
        addr = a;
        wdata = wd;
        wmask = wm;
        while (stall_s && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: stall=%b after %0d cycles, required 0", stall_s, n);
        end
        step();
        ncs[sel] = 1'b1;
        stalls = 0;
        while (stall_s && stalls < 40) begin
            step();
            stalls++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_tests++;
            if (stall_s !== 1'b0) begin n_fail++; $display("FAIL reset_stall[%0d]: got %b, required 0", s, stall_s); end
            n_tests++;
            if (err_s !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b, required 0", s, err_s); end
            n_tests++;
            if (rdata_s !== 64'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h, required 0", s, rdata_s); end
        end
        sel = 0;
        step();
    endtask

    task automatic test_write_read();
        int st;
        sel = 0;
        step();
        req(1'b1, BASE, V0, '1, st);
        n_tests++;
        if (st !== 2) begin n_fail++; $display("FAIL wr_stall: got %0d cycles, required 2", st); end
        n_tests++;
        if (err_s !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b, required 0", err_s); end
        req(1'b0, BASE, '0, '0, st);
        n_tests++;
        if (st !== 2) begin n_fail++; $display("FAIL rd_stall: got %0d cycles, required 2", st); end
        n_tests++;
        if (rdata_s !== V0) begin n_fail++; $display("FAIL rd_data: got %h, required %h", rdata_s, V0); end
        n_tests++;
        if (err_s !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b, required 0", err_s); end
    endtask

    task automatic test_masked_write();
        int st;
        sel = 0;
        req(1'b1, BASE + 32'd24, 64'h0, '1, st);
        req(1'b1, BASE + 32'd24, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, st);
        n_tests++;
        if (rdata_s !== V0) begin n_fail++; $display("FAIL wr_holds_rdata: got %h, required %h", rdata_s, V0); end
        req(1'b0, BASE + 32'd24, '0, '0, st);
        n_tests++;
        if (rdata_s !== 64'h0000_0000_FFFF_0000) begin
            n_fail++; $display("FAIL masked_data: got %h, required 00000000ffff0000", rdata_s);
        end
        n_tests++;
        if (st !== 2) begin n_fail++; $display("FAIL masked_rd_stall: got %0d, required 2", st); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [3];
        vals = '{64'h1111_1111_0000_0001, 64'h2222_2222_0000_0002, 64'h3333_3333_0000_0003};
        sel = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            ncs[1] = 1'b0; nwe = 1'b0; addr = BASE + 32'(8 * i); wdata = vals[i]; wmask = '1;
            n_tests++;
            if (stall_s !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_stall[%0d]: got %b, required 0", i, stall_s); end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                n_tests++;
                if (rdata_s !== vals[i-1]) begin
                    n_fail++; $display("FAIL b2b_rd_data[%0d]: got %h, required %h", i - 1, rdata_s, vals[i-1]);
                end
            end
            if (i < 3) begin
                ncs[1] = 1'b0; nwe = 1'b1; addr = BASE + 32'(8 * i);
                n_tests++;
                if (stall_s !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_stall[%0d]: got %b, required 0", i, stall_s); end
                step();
            end else begin
                ncs[1] = 1'b1;
            end
        end
        step();
    endtask

    task automatic test_out_of_range();
        int st;
        logic [31:0] bad [2];
        bad = '{32'h0FFF_FFF8, BASE + 32'(8 * DEPTH)};
        sel = 0;
        req(1'b1, BASE + 32'(8 * (DEPTH - 1)), VL, '1, st);
        for (int i = 0; i < 2; i++) begin
            req(1'b0, bad[i], '0, '0, st);
            n_tests++;
            if (rdata_s !== 64'h0) begin n_fail++; $display("FAIL oor_rdata[%0d]: got %h, required 0", i, rdata_s); end
            n_tests++;
            if (err_s !== 1'b1) begin n_fail++; $display("FAIL oor_err[%0d]: got %b, required 1", i, err_s); end
            step();
            n_tests++;
            if (err_s !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse[%0d]: got %b, required 0", i, err_s); end
        end
        for (int i = 0; i < 2; i++) begin
            req(1'b1, bad[i], 64'hDEAD_BEEF_DEAD_BEEF, '1, st);
            n_tests++;
            if (err_s !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err[%0d]: got %b, required 1", i, err_s); end
        end
        req(1'b0, BASE, '0, '0, st);
        n_tests++;
        if (rdata_s !== V0) begin n_fail++; $display("FAIL oor_line0: got %h, required %h", rdata_s, V0); end
        req(1'b0, BASE + 32'(8 * (DEPTH - 1)), '0, '0, st);
        n_tests++;
        if (rdata_s !== VL) begin n_fail++; $display("FAIL oor_last_line: got %h, required %h", rdata_s, VL); end
        n_tests++;
        if (err_s !== 1'b0) begin n_fail++; $display("FAIL last_line_err: got %b, required 0", err_s); end
    endtask

    task automatic test_reset_mid_wait();
        int st;
        int n;
        sel = 0;
        req(1'b1, BASE + 32'd40, V5, '1, st);
        ncs[0] = 1'b0; nwe = 1'b0; addr = BASE + 32'd40; wdata = ~V5; wmask = '1;
        n = 0;
        while (stall_s && n < 50) begin step(); n++; end
        step();
        ncs[0] = 1'b1;
        n_tests++;
        if (stall_s !== 1'b1) begin n_fail++; $display("FAIL rstw_in_wait: got stall %b, required 1", stall_s); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (stall_s !== 1'b0) begin n_fail++; $display("FAIL rstw_stall: got %b, required 0", stall_s); end
        n_tests++;
        if (err_s !== 1'b0) begin n_fail++; $display("FAIL rstw_err: got %b, required 0", err_s); end
        n_tests++;
        if (rdata_s !== 64'h0) begin n_fail++; $display("FAIL rstw_rdata: got %h, required 0", rdata_s); end
        req(1'b0, BASE + 32'd40, '0, '0, st);
        n_tests++;
        if (rdata_s !== V5) begin n_fail++; $display("FAIL rstw_line: got %h, required %h", rdata_s, V5); end
    endtask

    task automatic test_wait3();
        int st;
        logic [63:0] p2;
        p2 = 64'h0BAD_F00D_CAFE_0002;
        sel = 2;
        step();
`ifdef RISCV32IMA_IMEM_PREFETCH_EN
        req(1'b1, BASE, 64'h0BAD_F00D_CAFE_0000, '1, st);
        req(1'b1, BASE + 32'd8, 64'h0BAD_F00D_CAFE_0001, '1, st);
        req(1'b0, BASE, '0, '0, st);
        n_tests++;
        if (st !== 3) begin n_fail++; $display("FAIL pf_first_stall: got %0d, required 3", st); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (rdata_s !== 64'h0BAD_F00D_CAFE_0000) begin
                n_fail++; $display("FAIL pf_rdata_hold[%0d]: got %h, required 0badf00dcafe0000", i, rdata_s);
            end
        end
        req(1'b0, BASE + 32'd8, '0, '0, st);
        n_tests++;
        if (st !== 0) begin n_fail++; $display("FAIL pf_hit_stall: got %0d, required 0", st); end
        n_tests++;
        if (rdata_s !== 64'h0BAD_F00D_CAFE_0001) begin
            n_fail++; $display("FAIL pf_hit_data: got %h, required 0badf00dcafe0001", rdata_s);
        end
`endif
        req(1'b1, BASE + 32'd16, p2, '1, st);
        n_tests++;
        if (st !== 3) begin n_fail++; $display("FAIL ws3_wr_stall: got %0d, required 3", st); end
        req(1'b0, BASE + 32'd16, '0, '0, st);
        n_tests++;
        if (st !== 3) begin n_fail++; $display("FAIL ws3_rd_stall: got %0d, required 3", st); end
        n_tests++;
        if (rdata_s !== p2) begin n_fail++; $display("FAIL ws3_rd_data: got %h, required %h", rdata_s, p2); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (rdata_s !== p2) begin n_fail++; $display("FAIL ws3_rdata_stable[%0d]: got %h, required %h", i, rdata_s, p2); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_wait();
        test_wait3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
